// File: rtl/seq_scan_scheduler_pkg.sv
// Shared types and constants for the serial scan scheduler and its pattern detector.
package seq_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned PatLen = 7;
  localparam logic [PatLen-1:0] Pattern = 7'b0110110;
  // Longest proper suffix of the pattern that is also a prefix ("0110").
  localparam int unsigned OverlapLen = 4;

  // Number of pattern bits matched so far, 0..PatLen-1.
  typedef logic [2:0] det_state_t;

  // Pattern bit expected at position idx, first-received bit at idx 0.
  function automatic logic pat_bit(input det_state_t idx);
    return Pattern[3'(PatLen - 1) - idx];
  endfunction

endpackage

// File: rtl/serial_pattern_det.sv
// Overlapping serial detector for the shared pattern; hit is combinational on the final bit.
module serial_pattern_det
  import seq_scan_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in_bit,
  output logic hit
);

  det_state_t match_q, match_d;
  logic       expected;

  always_comb begin
    expected = pat_bit(match_q);
    hit      = (match_q == det_state_t'(PatLen - 1)) && (in_bit == expected);
    if (hit) begin
      match_d = det_state_t'(OverlapLen);
    end else if (in_bit == expected) begin
      match_d = match_q + 3'd1;
    end else begin
      // For this pattern a mismatching 0 always leaves prefix "0"; a mismatching 1 leaves nothing.
      match_d = in_bit ? det_state_t'(0) : det_state_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      match_q <= '0;
    end else begin
      match_q <= match_d;
    end
  end

endmodule

// File: rtl/seq_scan_scheduler.sv
// Two-requester round-robin scheduler that scans each granted word MSB first for pattern hits.
module seq_scan_scheduler
  import seq_scan_scheduler_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WORD_W-1:0] req_data0,
  input  logic [WORD_W-1:0] req_data1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [CNT_W-1:0]  resp_count,
  output logic              resp_hit,
  output logic              busy
);

  localparam int unsigned BitCntW = $clog2(WORD_W + 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]    hit_cnt_q;
  logic                id_q;
  logic                last_q;
  logic                grant_id;
  logic                grant_en;
  logic                det_hit;
  logic                det_clr;

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    grant_id = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (|req_valid && !rst) begin
          state_d   = StShift;
          req_ready = grant_id ? 2'b10 : 2'b01;
        end
      end
      StShift: begin
        if (bit_cnt_q == BitCntW'(WORD_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant_en = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      hit_cnt_q <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
    end else if (grant_en) begin
      shreg_q   <= grant_id ? req_data1 : req_data0;
      bit_cnt_q <= '0;
      hit_cnt_q <= '0;
      id_q      <= grant_id;
      last_q    <= grant_id;
    end else if (state_q == StShift) begin
      shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + BitCntW'(1);
      if (det_hit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
    end
  end

  // Holding the detector cleared outside SHIFT keeps each word's scan independent.
  assign det_clr = (state_q != StShift);

  serial_pattern_det u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (det_clr),
    .in_bit (shreg_q[WORD_W-1]),
    .hit    (det_hit)
  );

  assign resp_valid = (state_q == StDone);
  assign resp_id    = id_q;
  assign resp_count = hit_cnt_q;
  assign resp_hit   = |hit_cnt_q;

endmodule

// File: tb/tb_seq_scan_scheduler.sv
// Directed and randomized checks of seq_scan_scheduler against a sliding-window reference model.
module tb_seq_scan_scheduler;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready;
  logic [WORD_W-1:0] req_data0 = '0;
  logic [WORD_W-1:0] req_data1 = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_id;
  logic [CNT_W-1:0]  resp_count;
  logic              resp_hit;
  logic              busy;

  int errors = 0;
  int checks = 0;

  // Model state: pending requests, their words, and the last granted requester.
  logic [1:0]        pend = 2'b00;
  logic [WORD_W-1:0] word [2];
  int                last_gnt = 1;

  always #5 clk = ~clk;

  seq_scan_scheduler #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_count (resp_count),
    .resp_hit   (resp_hit),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count every 7-bit window equal to the pattern, MSB first, saturating.
  function automatic int ref_hits(input logic [WORD_W-1:0] w);
    logic [6:0] h;
    int n;
    h = '0;
    n = 0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      h = {h[5:0], w[i]};
      if ((WORD_W - i >= 7) && (h == 7'b0110110)) n++;
    end
    return (n > 31) ? 31 : n;
  endfunction

  // Present pending requests, expect the model's grant, then follow the scan to its response.
  task automatic transact(input int hold);
    int          exp_id;
    int          exp_cnt;
    int          lat;
    logic [1:0]  exp_rdy;
    logic        bad_ready;
    logic        bad_busy;
    logic        bad_stable;
    exp_id    = (pend == 2'b11) ? 1 - last_gnt : (pend[1] ? 1 : 0);
    exp_rdy   = (exp_id == 1) ? 2'b10 : 2'b01;
    req_data0 = word[0];
    req_data1 = word[1];
    req_valid = pend;
    #1;
    for (int k = 0; k < 50 && req_ready == 2'b00; k++) begin
      @(negedge clk);
      #1;
    end
    check("grant", 32'(req_ready), 32'(exp_rdy));
    exp_cnt       = ref_hits(word[exp_id]);
    last_gnt      = exp_id;
    pend[exp_id]  = 1'b0;
    bad_ready     = 1'b0;
    bad_busy      = 1'b0;
    lat           = 0;
    do begin
      @(negedge clk);
      req_valid = pend;
      #1;
      lat++;
      if (!busy) bad_busy = 1'b1;
      if (req_ready != 2'b00) bad_ready = 1'b1;
    end while (!resp_valid && lat < 100);
    check("latency", 32'(lat), 32'(WORD_W + 1));
    check("resp_id", 32'(resp_id), 32'(exp_id));
    check("resp_count", 32'(resp_count), 32'(exp_cnt));
    check("resp_hit", 32'(resp_hit), 32'(exp_cnt != 0));
    check("busy_during_scan", 32'(bad_busy), 32'(0));
    check("no_ready_during_scan", 32'(bad_ready), 32'(0));
    bad_stable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      if (!resp_valid || resp_id !== exp_id[0] || int'(resp_count) != exp_cnt ||
          req_ready != 2'b00) bad_stable = 1'b1;
    end
    if (hold > 0) check("done_hold_stable", 32'(bad_stable), 32'(0));
    resp_ready = 1'b1;
    #1;
    check("no_grant_on_release", 32'(req_ready), 32'(0));
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("single_response", 32'(resp_valid), 32'(0));
  endtask

  initial begin
    logic bad;
    word[0] = '0;
    word[1] = '0;

    // Reset with both requests raised: reset must win.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_resp_valid", 32'(resp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_resp_id", 32'(resp_id), 32'(0));
    check("rst_resp_count", 32'(resp_count), 32'(0));
    check("rst_resp_hit", 32'(resp_hit), 32'(0));
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;

    // A, B, C: single requesters with known words.
    pend = 2'b01; word[0] = 16'h6C00; transact(0);
    pend = 2'b10; word[1] = 16'h6DB6; transact(0);
    pend = 2'b01; word[0] = 16'hFFFF; transact(0);

    // D: contention right after reset, twice.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    last_gnt = 1;
    word[0]  = 16'($urandom);
    word[1]  = 16'($urandom);
    pend     = 2'b11;
    transact(0);
    transact(0);
    word[0]  = 16'h6DB6;
    word[1]  = 16'h0DB0;
    pend     = 2'b11;
    transact(0);
    transact(0);

    // E: long DONE hold while the other requester waits.
    word[0] = 16'h36C0;
    word[1] = 16'h6C6C;
    pend    = 2'b11;
    transact(5);
    transact(0);

    // F: reset mid-scan aborts the word.
    word[0]   = 16'h6DB6;
    pend      = 2'b01;
    req_data0 = word[0];
    req_valid = pend;
    #1;
    check("abort_grant", 32'(req_ready), 32'(1));
    repeat (9) @(negedge clk);
    req_valid = 2'b11;
    rst       = 1'b1;
    #1;
    check("rst_priority_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;
    pend      = 2'b00;
    last_gnt  = 1;
    bad       = 1'b0;
    for (int i = 0; i < WORD_W + 8; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid || busy) bad = 1'b1;
    end
    check("abort_no_response", 32'(bad), 32'(0));
    word[0] = 16'h6C00;
    word[1] = 16'hB600;
    pend    = 2'b11;
    transact(0);
    transact(0);

    // Randomized traffic with sticky pending requests.
    for (int n = 0; n < 16; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1;
          word[r] = 16'($urandom);
          if ($urandom_range(0, 2) == 0) word[r] = 16'h6DB6 ^ 16'($urandom & 32'h0000_8421);
        end
      end
      if (pend == 2'b00) begin
        pend[0] = 1'b1;
        word[0] = 16'($urandom);
      end
      transact(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
